// File: rtl/decode_stage.sv
// MiniSys-1A instruction decode stage: combinational MIPS-I decode into a registered
// output buffer (single register or two-entry skid), with flush and a reserved-instruction counter.
module decode_stage #(
    parameter int PC_W      = 32,
    parameter int OUT_DEPTH = 1,
    parameter int COP0_EN   = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       out_instr,
    output logic [5:0]        out_op_id,
    output logic [2:0]        out_class,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [31:0]       out_imm,
    output logic              out_reserved,
    output logic [CNT_W-1:0]  ri_count
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [5:0]      opId;
        logic [2:0]      cls;
        logic [31:0]     imm;
        logic            reserved;
    } entry_t;

    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rsField;
    logic [4:0] rtField;
    logic [5:0] opId;
    logic [2:0] cls;
    logic [31:0] imm;
    entry_t     decoded;

    assign op      = in_instr[31:26];
    assign func    = in_instr[5:0];
    assign rsField = in_instr[25:21];
    assign rtField = in_instr[20:16];

    // Instruction ID lookup; anything not matched stays 0 (reserved)
    always_comb begin
        opId = 6'd0;
        case (op)
            6'h00: begin
                case (func)
                    6'h20: opId = 6'd1;
                    6'h21: opId = 6'd2;
                    6'h22: opId = 6'd3;
                    6'h23: opId = 6'd4;
                    6'h18: opId = 6'd5;
                    6'h19: opId = 6'd6;
                    6'h1A: opId = 6'd7;
                    6'h1B: opId = 6'd8;
                    6'h24: opId = 6'd9;
                    6'h25: opId = 6'd10;
                    6'h26: opId = 6'd11;
                    6'h27: opId = 6'd12;
                    6'h00: opId = 6'd19;
                    6'h02: opId = 6'd20;
                    6'h03: opId = 6'd21;
                    6'h04: opId = 6'd22;
                    6'h06: opId = 6'd23;
                    6'h07: opId = 6'd24;
                    6'h2A: opId = 6'd35;
                    6'h2B: opId = 6'd37;
                    6'h08: opId = 6'd46;
                    6'h09: opId = 6'd48;
                    6'h10: opId = 6'd49;
                    6'h12: opId = 6'd50;
                    6'h11: opId = 6'd51;
                    6'h13: opId = 6'd52;
                    6'h0D: opId = 6'd53;
                    6'h0C: opId = 6'd54;
                    default: opId = 6'd0;
                endcase
            end
            6'h01: begin
                case (rtField)
                    5'b00000: opId = 6'd42;
                    5'b00001: opId = 6'd39;
                    5'b10000: opId = 6'd44;
                    5'b10001: opId = 6'd43;
                    default:  opId = 6'd0;
                endcase
            end
            6'h02: opId = 6'd45;
            6'h03: opId = 6'd47;
            6'h04: opId = 6'd33;
            6'h05: opId = 6'd34;
            6'h06: opId = (rtField == 5'd0) ? 6'd41 : 6'd0;
            6'h07: opId = (rtField == 5'd0) ? 6'd40 : 6'd0;
            6'h08: opId = 6'd13;
            6'h09: opId = 6'd14;
            6'h0A: opId = 6'd36;
            6'h0B: opId = 6'd38;
            6'h0C: opId = 6'd15;
            6'h0D: opId = 6'd16;
            6'h0E: opId = 6'd17;
            6'h0F: opId = 6'd18;
            6'h10: begin
                if (COP0_EN != 0) begin
                    if (rsField == 5'b00000)
                        opId = 6'd56;
                    else if (rsField == 5'b00100)
                        opId = 6'd57;
                    else if (rsField == 5'b10000 && func == 6'h18)
                        opId = 6'd55;
                end
            end
            6'h20: opId = 6'd25;
            6'h24: opId = 6'd26;
            6'h21: opId = 6'd27;
            6'h25: opId = 6'd28;
            6'h23: opId = 6'd29;
            6'h28: opId = 6'd30;
            6'h29: opId = 6'd31;
            6'h2B: opId = 6'd32;
            default: opId = 6'd0;
        endcase
    end

    // Class and immediate follow from the ID alone
    always_comb begin
        cls = 3'd7;
        if (opId inside {[6'd1:6'd4], [6'd9:6'd12], [6'd19:6'd24], 6'd35, 6'd37})
            cls = 3'd0;
        else if (opId inside {[6'd13:6'd18], 6'd36, 6'd38})
            cls = 3'd1;
        else if (opId inside {[6'd25:6'd29]})
            cls = 3'd2;
        else if (opId inside {[6'd30:6'd32]})
            cls = 3'd3;
        else if (opId inside {6'd33, 6'd34, [6'd39:6'd44]})
            cls = 3'd4;
        else if (opId inside {[6'd45:6'd48]})
            cls = 3'd5;
        else if (opId inside {[6'd5:6'd8], [6'd49:6'd52]})
            cls = 3'd6;

        imm = {{16{in_instr[15]}}, in_instr[15:0]};
        if (opId inside {[6'd15:6'd17]})
            imm = {16'h0000, in_instr[15:0]};
        else if (opId == 6'd18)
            imm = {in_instr[15:0], 16'h0000};

        decoded.pc       = in_pc;
        decoded.instr    = in_instr;
        decoded.opId     = opId;
        decoded.cls      = cls;
        decoded.imm      = imm;
        decoded.reserved = (opId == 6'd0);
    end

    entry_t            main_q, main_d, skid_q, skid_d;
    logic              mainValid_q, mainValid_d, skidValid_q, skidValid_d;
    logic [CNT_W-1:0]  riCount_q, riCount_d;
    logic              accept;
    logic              consume;

    // Buffer control: skid can only fill while main is stalled, and in_ready
    // blocks new input while skid is full, so accept never coincides with a skid move
    always_comb begin
        main_d      = main_q;
        mainValid_d = mainValid_q;
        skid_d      = skid_q;
        skidValid_d = skidValid_q;
        riCount_d   = riCount_q;

        if (OUT_DEPTH == 2)
            in_ready = ~skidValid_q;
        else
            in_ready = ~mainValid_q | out_ready;

        accept  = in_valid & in_ready & ~flush;
        consume = mainValid_q & out_ready;

        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (OUT_DEPTH == 2) begin
            if (consume) begin
                if (skidValid_q) begin
                    main_d      = skid_q;
                    skidValid_d = 1'b0;
                end else if (accept) begin
                    main_d = decoded;
                end else begin
                    mainValid_d = 1'b0;
                end
            end else if (!mainValid_q) begin
                if (accept) begin
                    main_d      = decoded;
                    mainValid_d = 1'b1;
                end
            end else if (accept) begin
                skid_d      = decoded;
                skidValid_d = 1'b1;
            end
        end else begin
            if (accept) begin
                main_d      = decoded;
                mainValid_d = 1'b1;
            end else if (consume) begin
                mainValid_d = 1'b0;
            end
        end

        if (accept && decoded.reserved && (riCount_q != {CNT_W{1'b1}}))
            riCount_d = riCount_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            riCount_q   <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            riCount_q   <= riCount_d;
        end
    end

    assign out_valid    = mainValid_q;
    assign out_pc       = main_q.pc;
    assign out_instr    = main_q.instr;
    assign out_op_id    = main_q.opId;
    assign out_class    = main_q.cls;
    assign out_rs       = main_q.instr[25:21];
    assign out_rt       = main_q.instr[20:16];
    assign out_rd       = main_q.instr[15:11];
    assign out_shamt    = main_q.instr[10:6];
    assign out_imm      = main_q.imm;
    assign out_reserved = main_q.reserved;
    assign ri_count     = riCount_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: dutA (depth 1, COP0 on, 8-bit counter) and dutB (depth 2,
// COP0 off, 2-bit counter) share one stimulus stream; table vectors plus directed sequences.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [31:0] inInstr;
    logic [31:0] inPc;
    logic        flush;
    logic        outReady;

    logic        inReadyA, outValidA, outReservedA;
    logic [31:0] outPcA, outInstrA, outImmA;
    logic [5:0]  outOpIdA;
    logic [2:0]  outClassA;
    logic [4:0]  outRsA, outRtA, outRdA, outShamtA;
    logic [7:0]  riCountA;

    logic        inReadyB, outValidB, outReservedB;
    logic [31:0] outPcB, outInstrB, outImmB;
    logic [5:0]  outOpIdB;
    logic [2:0]  outClassB;
    logic [4:0]  outRsB, outRtB, outRdB, outShamtB;
    logic [1:0]  riCountB;

    int passCount;
    int totalCount;

    decode_stage #(.PC_W(32), .OUT_DEPTH(1), .COP0_EN(1), .CNT_W(8)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyA),
        .in_instr(inInstr), .in_pc(inPc), .flush(flush),
        .out_valid(outValidA), .out_ready(outReady), .out_pc(outPcA),
        .out_instr(outInstrA), .out_op_id(outOpIdA), .out_class(outClassA),
        .out_rs(outRsA), .out_rt(outRtA), .out_rd(outRdA), .out_shamt(outShamtA),
        .out_imm(outImmA), .out_reserved(outReservedA), .ri_count(riCountA)
    );

    decode_stage #(.PC_W(32), .OUT_DEPTH(2), .COP0_EN(0), .CNT_W(2)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyB),
        .in_instr(inInstr), .in_pc(inPc), .flush(flush),
        .out_valid(outValidB), .out_ready(outReady), .out_pc(outPcB),
        .out_instr(outInstrB), .out_op_id(outOpIdB), .out_class(outClassB),
        .out_rs(outRsB), .out_rt(outRtB), .out_rd(outRdB), .out_shamt(outShamtB),
        .out_imm(outImmB), .out_reserved(outReservedB), .ri_count(riCountB)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  id;
        logic [2:0]  cls;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[21];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic fl, input logic rdy);
        inValid  = v;
        inInstr  = instr;
        inPc     = pc;
        flush    = fl;
        outReady = rdy;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse started between edges, released one edge later
    task automatic pulseReset();
        rst = 1'b1;
        #1;
        checkOutput("asyncRst outValidA", {31'd0, outValidA}, 32'd0);
        checkOutput("asyncRst outValidB", {31'd0, outValidB}, 32'd0);
        checkOutput("asyncRst inReadyB", {31'd0, inReadyB}, 32'd1);
        checkOutput("asyncRst riCountA", {24'd0, riCountA}, 32'd0);
        stepCycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [5:0]  idB;
        logic [2:0]  clsB;
        int          riA;
        int          riB;

        passCount  = 0;
        totalCount = 0;

        vecs[0]  = '{32'h012A4020, 6'd1,  3'd0, 32'h00004020};
        vecs[1]  = '{32'h3C011234, 6'd18, 3'd1, 32'h12340000};
        vecs[2]  = '{32'h3021FFFF, 6'd15, 3'd1, 32'h0000FFFF};
        vecs[3]  = '{32'h2021FFFF, 6'd13, 3'd1, 32'hFFFFFFFF};
        vecs[4]  = '{32'h40086000, 6'd56, 3'd7, 32'h00006000};
        vecs[5]  = '{32'h00000000, 6'd19, 3'd0, 32'h00000000};
        vecs[6]  = '{32'hFC000000, 6'd0,  3'd7, 32'h00000000};
        vecs[7]  = '{32'h8D09FFFC, 6'd29, 3'd2, 32'hFFFFFFFC};
        vecs[8]  = '{32'hAD090004, 6'd32, 3'd3, 32'h00000004};
        vecs[9]  = '{32'h1509FFFE, 6'd34, 3'd4, 32'hFFFFFFFE};
        vecs[10] = '{32'h1D200001, 6'd40, 3'd4, 32'h00000001};
        vecs[11] = '{32'h1D210001, 6'd0,  3'd7, 32'h00000001};
        vecs[12] = '{32'h04110008, 6'd43, 3'd4, 32'h00000008};
        vecs[13] = '{32'h03E00008, 6'd46, 3'd5, 32'h00000008};
        vecs[14] = '{32'h0C000010, 6'd47, 3'd5, 32'h00000010};
        vecs[15] = '{32'h012A0018, 6'd5,  3'd6, 32'h00000018};
        vecs[16] = '{32'h0000000C, 6'd54, 3'd7, 32'h0000000C};
        vecs[17] = '{32'h42000018, 6'd55, 3'd7, 32'h00000018};
        vecs[18] = '{32'h3421FFFF, 6'd16, 3'd1, 32'h0000FFFF};
        vecs[19] = '{32'h00094043, 6'd21, 3'd0, 32'h00004043};
        vecs[20] = '{32'h0000003F, 6'd0,  3'd7, 32'h0000003F};

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        stepCycle();

        // Reset state
        checkOutput("reset outValidA", {31'd0, outValidA}, 32'd0);
        checkOutput("reset inReadyA", {31'd0, inReadyA}, 32'd1);
        checkOutput("reset outValidB", {31'd0, outValidB}, 32'd0);
        checkOutput("reset inReadyB", {31'd0, inReadyB}, 32'd1);
        checkOutput("reset riCountA", {24'd0, riCountA}, 32'd0);
        checkOutput("reset riCountB", {30'd0, riCountB}, 32'd0);
        checkOutput("reset outOpIdA", {26'd0, outOpIdA}, 32'd0);
        checkOutput("reset outImmA", outImmA, 32'd0);
        checkOutput("reset outPcB", outPcB, 32'd0);
        rst = 1'b0;

        // Five reserved words: dutB counter saturates at 3
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 32'hFC000000, 32'h100, 1'b0, 1'b1);
            stepCycle();
            checkOutput($sformatf("sat riCountA k=%0d", k), {24'd0, riCountA}, k);
            checkOutput($sformatf("sat riCountB k=%0d", k), {30'd0, riCountB}, (k > 3) ? 3 : k);
            checkOutput("sat outReservedB", {31'd0, outReservedB}, 32'd1);
        end

        // Reset while entries are held
        pulseReset();

        // Table vectors streamed back to back with out_ready high
        riA = 0;
        riB = 0;
        for (int i = 0; i < 21; i++) begin
            w = vecs[i].instr;
            applyStimulus(1'b1, w, 32'h1000 + 32'(i * 4), 1'b0, 1'b1);
            stepCycle();
            if (vecs[i].id inside {6'd55, 6'd56, 6'd57}) begin
                idB  = 6'd0;
                clsB = 3'd7;
            end else begin
                idB  = vecs[i].id;
                clsB = vecs[i].cls;
            end
            if (vecs[i].id == 6'd0)
                riA++;
            if (idB == 6'd0 && riB < 3)
                riB++;
            checkOutput($sformatf("vec%0d validA", i), {31'd0, outValidA}, 32'd1);
            checkOutput($sformatf("vec%0d opIdA", i), {26'd0, outOpIdA}, {26'd0, vecs[i].id});
            checkOutput($sformatf("vec%0d classA", i), {29'd0, outClassA}, {29'd0, vecs[i].cls});
            checkOutput($sformatf("vec%0d immA", i), outImmA, vecs[i].imm);
            checkOutput($sformatf("vec%0d reservedA", i), {31'd0, outReservedA}, {31'd0, vecs[i].id == 6'd0});
            checkOutput($sformatf("vec%0d fieldsA", i), {12'd0, outRsA, outRtA, outRdA, outShamtA},
                        {12'd0, w[25:21], w[20:16], w[15:11], w[10:6]});
            checkOutput($sformatf("vec%0d pcA", i), outPcA, 32'h1000 + 32'(i * 4));
            checkOutput($sformatf("vec%0d instrA", i), outInstrA, w);
            checkOutput($sformatf("vec%0d riCountA", i), {24'd0, riCountA}, riA);
            checkOutput($sformatf("vec%0d validB", i), {31'd0, outValidB}, 32'd1);
            checkOutput($sformatf("vec%0d opIdB", i), {26'd0, outOpIdB}, {26'd0, idB});
            checkOutput($sformatf("vec%0d classB", i), {29'd0, outClassB}, {29'd0, clsB});
            checkOutput($sformatf("vec%0d immB", i), outImmB, vecs[i].imm);
            checkOutput($sformatf("vec%0d reservedB", i), {31'd0, outReservedB}, {31'd0, idB == 6'd0});
            checkOutput($sformatf("vec%0d riCountB", i), {30'd0, riCountB}, riB);
        end

        // Skid fill with out_ready low, then drain in order
        pulseReset();
        applyStimulus(1'b1, 32'h012A4020, 32'h2000, 1'b0, 1'b0);
        stepCycle();
        checkOutput("skid A held opIdB", {26'd0, outOpIdB}, 32'd1);
        checkOutput("skid inReadyB after A", {31'd0, inReadyB}, 32'd1);
        checkOutput("skid inReadyA stalled", {31'd0, inReadyA}, 32'd0);
        applyStimulus(1'b1, 32'h3C011234, 32'h2004, 1'b0, 1'b0);
        stepCycle();
        checkOutput("skid inReadyB full", {31'd0, inReadyB}, 32'd0);
        checkOutput("skid stable opIdB", {26'd0, outOpIdB}, 32'd1);
        checkOutput("skid stable opIdA", {26'd0, outOpIdA}, 32'd1);
        applyStimulus(1'b1, 32'h3021FFFF, 32'h2008, 1'b0, 1'b0);
        stepCycle();
        checkOutput("skid C refused inReadyB", {31'd0, inReadyB}, 32'd0);
        checkOutput("skid stable pcB", outPcB, 32'h2000);
        applyStimulus(1'b1, 32'h3021FFFF, 32'h2008, 1'b0, 1'b1);
        #1;
        checkOutput("drain inReadyA comb", {31'd0, inReadyA}, 32'd1);
        checkOutput("drain first opIdB", {26'd0, outOpIdB}, 32'd1);
        stepCycle();
        checkOutput("drain second opIdB", {26'd0, outOpIdB}, 32'd18);
        checkOutput("drain second pcB", outPcB, 32'h2004);
        checkOutput("drain inReadyB back", {31'd0, inReadyB}, 32'd1);
        checkOutput("drain depth1 opIdA", {26'd0, outOpIdA}, 32'd15);
        stepCycle();
        checkOutput("drain third opIdB", {26'd0, outOpIdB}, 32'd15);
        checkOutput("drain third validB", {31'd0, outValidB}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("drain empty validB", {31'd0, outValidB}, 32'd0);

        // Flush with two held entries and a reserved word incoming
        pulseReset();
        applyStimulus(1'b1, 32'h012A4020, 32'h3000, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h3C011234, 32'h3004, 1'b0, 1'b0);
        stepCycle();
        checkOutput("flush pre inReadyB", {31'd0, inReadyB}, 32'd0);
        applyStimulus(1'b1, 32'hFC000000, 32'h3008, 1'b1, 1'b1);
        stepCycle();
        checkOutput("flush validA", {31'd0, outValidA}, 32'd0);
        checkOutput("flush validB", {31'd0, outValidB}, 32'd0);
        checkOutput("flush inReadyA", {31'd0, inReadyA}, 32'd1);
        checkOutput("flush inReadyB", {31'd0, inReadyB}, 32'd1);
        checkOutput("flush riCountA", {24'd0, riCountA}, 32'd0);
        checkOutput("flush riCountB", {30'd0, riCountB}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("post flush validA", {31'd0, outValidA}, 32'd0);
        checkOutput("post flush validB", {31'd0, outValidB}, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
